// File: rtl/bcd_counter.sv
// bcd_counter: single-digit decade counter with parallel load and carry for digit cascading.
// Define BCD_LOAD_CHECK_EN to reject out-of-range loads; otherwise they are reduced into range.
module bcd_counter #(
    parameter int MAX_COUNT = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Load,
    input  logic [3:0] Bcd_in,
    output logic [3:0] Q_out,
    output logic       Carry_out
);
    localparam logic [3:0] MAX = 4'(MAX_COUNT);
    logic       load_ok;
    logic [3:0] load_val;
    logic [3:0] q_next;
`ifdef BCD_LOAD_CHECK_EN
    assign load_ok  = Bcd_in <= MAX;
    assign load_val = Bcd_in;
`else
    localparam logic [4:0] MOD = 5'(MAX_COUNT + 1);
    logic [4:0] reduced;
    // modulo matches Bcd_in-(MAX_COUNT+1) for decimal use and stays in range for small MAX_COUNT
    assign reduced  = {1'b0, Bcd_in} % MOD;
    assign load_ok  = 1'b1;
    assign load_val = reduced[3:0];
`endif
    always_comb begin
        q_next = Load ? (load_ok ? load_val : Q_out) : (Q_out >= MAX ? 4'd0 : Q_out + 4'd1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) Q_out <= 4'd0;
        else        Q_out <= q_next;
    end
    assign Carry_out = (Q_out == MAX) && !Load;
endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: directed checks of reset, wrap, load, terminal load, illegal load and mid-run reset.
module tb_bcd_counter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       Load;
    logic [3:0] Bcd_in;
    logic [3:0] Q_out;
    logic       Carry_out;
    int         errors = 0;
    int         checks = 0;

    bcd_counter #(.MAX_COUNT(9)) dut (
        .clk(clk), .rst_n(rst_n), .Load(Load), .Bcd_in(Bcd_in),
        .Q_out(Q_out), .Carry_out(Carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] q_exp, input logic c_exp);
        checks++;
        assert (Q_out === q_exp) else begin
            errors++;
            $error("FAIL %s q: got %0h expected %0h", tag, Q_out, q_exp);
        end
        checks++;
        assert (Carry_out === c_exp) else begin
            errors++;
            $error("FAIL %s carry: got %b expected %b", tag, Carry_out, c_exp);
        end
    endtask

    task automatic tick_chk(input string tag, input logic [3:0] q_exp, input logic c_exp);
        @(negedge clk);
        chk(tag, q_exp, c_exp);
    endtask

    initial begin
        logic [3:0] illegal_exp;
        rst_n = 1'b1; Load = 1'b0; Bcd_in = 4'd0;
        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_chk("rel1", 4'd1, 1'b0);
        tick_chk("rel2", 4'd2, 1'b0);
        tick_chk("rel3", 4'd3, 1'b0);
        // wrap: two full decades from 0, Bcd_in unknown while not loading
        Load = 1'b1; Bcd_in = 4'd0;
        tick_chk("load0", 4'd0, 1'b0);
        Load = 1'b0; Bcd_in = 4'bxxxx;
        for (int r = 0; r < 2; r++)
            for (int i = 1; i <= 10; i++) begin
                logic [3:0] e;
                e = (i == 10) ? 4'd0 : 4'(i);
                tick_chk("wrap", e, e == 4'd9);
            end
        // load then count, then held load
        Load = 1'b1; Bcd_in = 4'd1;
        tick_chk("load1", 4'd1, 1'b0);
        Load = 1'b0;
        tick_chk("cnt2", 4'd2, 1'b0);
        tick_chk("cnt3", 4'd3, 1'b0);
        Load = 1'b1; Bcd_in = 4'd7;
        tick_chk("hold7a", 4'd7, 1'b0);
        tick_chk("hold7b", 4'd7, 1'b0);
        tick_chk("hold7c", 4'd7, 1'b0);
        // load at terminal count
        Load = 1'b0;
        tick_chk("cnt8", 4'd8, 1'b0);
        tick_chk("cnt9", 4'd9, 1'b1);
        Load = 1'b1; Bcd_in = 4'd4;
        #1 chk("carry_masked", 4'd9, 1'b0);
        tick_chk("term_load4", 4'd4, 1'b0);
        // out-of-range load
        Bcd_in = 4'd3;
        tick_chk("load3", 4'd3, 1'b0);
        Bcd_in = 4'd12;
`ifdef BCD_LOAD_CHECK_EN
        illegal_exp = 4'd3;
`else
        illegal_exp = 4'd2;
`endif
        tick_chk("illegal12", illegal_exp, 1'b0);
`ifndef BCD_LOAD_CHECK_EN
        Bcd_in = 4'd15;
        tick_chk("illegal15", 4'd5, 1'b0);
`endif
        // reset mid-run discards a pending load
        Bcd_in = 4'd6;
        tick_chk("load6", 4'd6, 1'b0);
        Bcd_in = 4'd8;
        #2 rst_n = 1'b0;
        #1 chk("reset_mid", 4'd0, 1'b0);
        tick_chk("reset_hold", 4'd0, 1'b0);
        Load = 1'b0;
        rst_n = 1'b1;
        tick_chk("restart1", 4'd1, 1'b0);
        tick_chk("restart2", 4'd2, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
